// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler for the five-stage pipeline
// Handles load-use hazards, Execute redirects, memory-wait freeze, watchdog and event counters.
module pipeline_ctrl #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  RedirectCount
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic memwait;
  logic loaduse;
  logic redirect;

  assign memwait = MemReqM & ~MemReadyM;
  assign loaduse = ResultSrcE0 & RegWriteE & (RdE != '0) &
                   ((RdE == Rs1D) | (RdE == Rs2D));

  // Priority: reset, error, memory freeze, redirect, load-use.
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    redirect = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state_q == ERROR || memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      redirect = 1'b1;
    end else if (loaduse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (memwait) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          // The cycle with wait_q == TIMEOUT-1 is the TIMEOUT-th stalled cycle.
          if (wait_q == WW'(TIMEOUT - 1)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign MemErr        = err_q;
  assign StallCount    = stall_cnt_q;
  assign RedirectCount = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed table and sequence bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdE = '0;
  logic       RegWriteE = 1'b0, ResultSrcE0 = 1'b0, PCSrcE = 1'b0;
  logic       MemReqM = 1'b0, MemReadyM = 1'b0;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [3:0] StallCount, RedirectCount;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCount(StallCount), .RedirectCount(RedirectCount)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc, mreq, mrdy;
    logic [3:0] stl;  // {F,D,E,M}
    logic [2:0] fl;   // {D,E,W}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] stl, input logic [2:0] fl);
    chk({name, ".stall"}, int'({StallF, StallD, StallE, StallM}), int'(stl));
    chk({name, ".flush"}, int'({FlushD, FlushE, FlushW}), int'(fl));
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; RdE = '0;
    RegWriteE = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic set_loaduse();
    RdE = 5'd5; Rs2D = 5'd5; RegWriteE = 1'b1; ResultSrcE0 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
    vecs[1] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b010};
    vecs[2] = '{5'd0,  5'd3,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
    vecs[3] = '{5'd5,  5'd2,  5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
    vecs[4] = '{5'd5,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
    vecs[5] = '{5'd9,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b110};
    vecs[6] = '{5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b110};
    vecs[7] = '{5'd4,  5'd4,  5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 3'b010};
    vecs[8] = '{5'd31, 5'd0,  5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b010};
    vecs[9] = '{5'd6,  5'd8,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000};

    // Reset state
    #2;
    chk_out("reset", 4'b0000, 3'b111);
    chk("reset.MemErr", int'(MemErr), 0);
    chk("reset.StallCount", int'(StallCount), 0);
    chk("reset.RedirectCount", int'(RedirectCount), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational priority table, all in RUN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1; Rs2D = vecs[i].rs2; RdE = vecs[i].rd;
      RegWriteE = vecs[i].rw; ResultSrcE0 = vecs[i].ld; PCSrcE = vecs[i].pc;
      MemReqM = vecs[i].mreq; MemReadyM = vecs[i].mrdy;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].stl, vecs[i].fl);
    end

    // Single load-use stall
    do_reset();
    set_loaduse();
    #1;
    chk_out("lu", 4'b1100, 3'b010);
    @(negedge clk);
    idle();
    #1;
    chk_out("lu.after", 4'b0000, 3'b000);
    chk("lu.StallCount", int'(StallCount), 1);

    // Branch overrides load-use
    @(negedge clk);
    set_loaduse();
    PCSrcE = 1'b1;
    #1;
    chk_out("br_lu", 4'b0000, 3'b110);
    @(negedge clk);
    idle();
    #1;
    chk("br_lu.RedirectCount", int'(RedirectCount), 1);
    chk("br_lu.StallCount", int'(StallCount), 1);

    // Three-cycle memory wait with a deferred redirect
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_out($sformatf("mw%0d", c), 4'b1111, 3'b001);
      @(negedge clk);
    end
    MemReadyM = 1'b1;
    #1;
    chk_out("mw.release", 4'b0000, 3'b110);
    chk("mw.MemErr", int'(MemErr), 0);
    @(negedge clk);
    idle();
    #1;
    chk_out("mw.idle", 4'b0000, 3'b000);
    chk("mw.StallCount", int'(StallCount), 3);
    chk("mw.RedirectCount", int'(RedirectCount), 1);

    // Watchdog: TIMEOUT=4 stalled cycles -> sticky error
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("wd%0d.MemErr", c), int'(MemErr), 0);
      @(negedge clk);
    end
    idle();
    #1;
    chk("wd.MemErr", int'(MemErr), 1);
    chk_out("wd.err", 4'b1111, 3'b001);
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    chk_out("wd.err_hold", 4'b1111, 3'b001);
    chk("wd.StallCount", int'(StallCount), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wd.rst.MemErr", int'(MemErr), 0);
    chk_out("wd.rst", 4'b0000, 3'b111);
    chk("wd.rst.StallCount", int'(StallCount), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    chk_out("wd.run", 4'b0000, 3'b000);

    // Reset asserted mid memory wait
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mwrst", 4'b0000, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk_out("mwrst.run", 4'b0000, 3'b000);
    chk("mwrst.StallCount", int'(StallCount), 0);

    // Saturation: 20 load-use cycles with CNT_W=4
    do_reset();
    set_loaduse();
    for (int c = 0; c < 20; c++) @(negedge clk);
    idle();
    #1;
    chk("sat.StallCount", int'(StallCount), 15);

    // Redirect counter saturation
    PCSrcE = 1'b1;
    for (int c = 0; c < 18; c++) @(negedge clk);
    idle();
    #1;
    chk("sat.RedirectCount", int'(RedirectCount), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the five-stage RISC-V pipeline. Detects load-use hazards in Decode, redirects on taken branches/jumps resolved in Execute, and freezes the pipeline while a variable-latency data-memory access in Memory is outstanding. It owns a memory-wait watchdog and two saturating event counters. Operand forwarding is handled by the separate forwarding logic; this block only issues stall and flush enables to the pipeline registers.

## Interface
- REG_AW, 5: register-address width
- TIMEOUT, 16: max consecutive memory-wait cycles before error (≥2)
- CNT_W, 16: width of event counters
---
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  REG_AW  source registers of instruction in Decode
- RdE  in  REG_AW  destination of instruction in Execute
- RegWriteE  in  1  Execute instruction writes a register
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- MemReqM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  load bubble into corresponding register
- MemErr  out  1  sticky watchdog error
- StallCount  out  CNT_W  cycles with StallF=1, saturating
- RedirectCount  out  CNT_W  taken-branch redirects, saturating

## Operation
- States: RUN, MEM_WAIT, ERROR (2-bit register).
- memwait = MemReqM & ~MemReadyM.
- loaduse = ResultSrcE0 & RegWriteE & (RdE≠0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- Outputs combinational from state and inputs; priority, highest first:
  - ERROR: StallF/D/E/M=1, FlushW=1, FlushD/E=0.
  - memwait (RUN or MEM_WAIT): StallF/D/E/M=1, FlushW=1, FlushD/E=0. Branch and load-use held, acted on after release.
  - PCSrcE: FlushD=1, FlushE=1, no stalls. Overrides load-use (Decode instruction squashed).
  - loaduse: StallF=1, StallD=1, FlushE=1.
  - else all 0.
- Transitions:
  - RUN → MEM_WAIT on memwait; wait counter ← 1.
  - MEM_WAIT: memwait → stay, wait counter +1; MemReadyM=1 or MemReqM=0 → RUN, counter ← 0. Stalls drop in the same cycle MemReadyM rises.
  - MEM_WAIT → ERROR when memwait and wait counter == TIMEOUT−1 (i.e. TIMEOUT stalled cycles elapsed); MemErr ← 1.
  - ERROR: terminal until rst_n.
- Wait counter width clog2(TIMEOUT+1); cleared in RUN.
- StallCount +1 every cycle StallF=1; RedirectCount +1 every cycle FlushD=1 due to PCSrcE. Both saturate at 2^CNT_W−1, no wrap.
- Register x0 never creates a load-use hazard.

## Timing
- Reset (rst_n=0, async): state RUN, wait counter 0, MemErr 0, counters 0; while rst_n=0 all Stall*=0, FlushD/E/W=1.
- First edge after rst_n release: normal RUN behaviour.
- Load-use: exactly one stall cycle; next cycle Execute holds a bubble, loaduse naturally deasserts.
- Memory wait of N cycles (N<TIMEOUT): N stall cycles, zero added latency on release.
- Branch: flush asserted in the cycle PCSrcE=1 is sampled; one-cycle event.
- memwait coinciding with PCSrcE: redirect deferred until memory completes; PCSrcE remains valid since Execute is frozen.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to reset values.

## Test plan
- Load x5 in E (RdE=5, ResultSrcE0=1, RegWriteE=1), Rs2D=5 → StallF=StallD=FlushE=1 one cycle; StallCount=1.
- Same with RdE=0, Rs1D=0 → no stall/flush.
- PCSrcE=1 together with load-use → FlushD=FlushE=1, StallF=0; RedirectCount=1.
- MemReqM=1, MemReadyM low 3 cycles then high → StallF/D/E/M and FlushW high exactly 3 cycles, state back to RUN, StallCount=3.
- TIMEOUT=4, MemReadyM never rises → MemErr=1 after 4 stalled cycles, stalls stay asserted; rst_n low → MemErr=0, all Flush=1, Stall=0.
- CNT_W=4, 20 consecutive load-use cycles → StallCount holds at 15.
